// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN to add the signed_op port for two's-complement operation.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  // Handshake: start is accepted on a rising edge only while busy is low; done
  // pulses for one cycle with results valid, and results hold until the next done.
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] q_reg_q, q_reg_d;
  logic [WIDTH-1:0] rem_reg_q, rem_reg_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             sop;
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign sop = signed_op;
`else
  assign sop = 1'b0;
`endif

  assign partial = {rem_reg_q, q_reg_q[WIDTH-1]};
  assign trial   = partial - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    q_reg_d   = q_reg_q;
    rem_reg_d = rem_reg_q;
    dvs_d     = dvs_q;
    dvd_d     = dvd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dbz_d     = dbz_q;
    case (state_q)
      RUN: begin
        if (!trial[WIDTH]) begin
          rem_reg_d = trial[WIDTH-1:0];
          q_reg_d   = {q_reg_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_reg_d = partial[WIDTH-1:0];
          q_reg_d   = {q_reg_q[WIDTH-2:0], 1'b0};
        end
        count_d = count_q - 1'b1;
        if (count_q == '0) state_d = DONE;
      end
      default: begin
        // DONE with busy still high is the result-publishing edge
        if (state_q == DONE && busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          if (dvs_q == '0) begin
            quo_d = '1;
            rem_d = dvd_q;
            dbz_d = 1'b1;
          end else begin
            quo_d = neg_quo_q ? -q_reg_q : q_reg_q;
            rem_d = neg_rem_q ? -rem_reg_q : rem_reg_q;
          end
        end else if (start) begin
          dvd_d     = dividend;
          dvs_d     = (sop && divisor[WIDTH-1]) ? -divisor : divisor;
          q_reg_d   = (sop && dividend[WIDTH-1]) ? -dividend : dividend;
          rem_reg_d = '0;
          count_d   = CW'(WIDTH - 1);
          neg_quo_d = sop & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = sop & dividend[WIDTH-1];
          busy_d    = 1'b1;
          dbz_d     = 1'b0;
          state_d   = (divisor == '0) ? DONE : RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      q_reg_q   <= '0;
      rem_reg_q <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      q_reg_q   <= q_reg_d;
      rem_reg_q <= rem_reg_d;
      dvs_q     <= dvs_d;
      dvd_q     <= dvd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes expected results, monitor checks on done.
module tb_seq_divider;
  localparam int W  = 4;
  localparam int EW = 16 + 2 * W + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  logic [1:0]   state_dbg;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic         signed_op = 1'b0;
`endif

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .signed_op(signed_op),
`endif
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: present operands with start, push expected result and done cycle
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed);
    int lat;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = (b == '0) ? 1 : W + 1;
    exp_q.push_back({16'(cyc + lat), eq, er, ed});
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_timeout", {31'd0, seen}, 32'd1);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), {16'd0, e[EW-1:2*W+1]});
        chk("quotient", {28'd0, quotient}, {28'd0, e[2*W:W+1]});
        chk("remainder", {28'd0, remainder}, {28'd0, e[W:1]});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[0]});
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    logic [W-1:0] ea, eb, eq, er;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_quotient", {28'd0, quotient}, 32'd0);
    chk("reset_remainder", {28'd0, remainder}, 32'd0);
    chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
    wait_done();
    @(negedge clk);
    issue(4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
    wait_done();

    // back-to-back, each start in the done cycle
    issue(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    wait_done();
    issue(4'd2, 4'd5, 4'd0, 4'd2, 1'b0);
    wait_done();
    issue(4'd5, 4'd5, 4'd1, 4'd0, 1'b0);
    wait_done();

    // start while busy is ignored
    @(negedge clk);
    issue(4'd9, 4'd2, 4'd4, 4'd1, 1'b0);
    @(negedge clk);
    dividend = 4'd1;
    divisor  = 4'd1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_ignored_start", {31'd0, busy}, 32'd1);
    wait_done();

    // reset mid-operation
    @(negedge clk);
    issue(4'd14, 4'd3, 4'd4, 4'd2, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_quotient", {28'd0, quotient}, 32'd0);
    chk("abort_remainder", {28'd0, remainder}, 32'd0);
    chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(4'd6, 4'd4, 4'd1, 4'd2, 1'b0);
    wait_done();

    // every operand pair, back-to-back
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        ea = 4'(i);
        eb = 4'(j);
        if (j == 0) begin
          eq = 4'hf;
          er = ea;
        end else begin
          eq = 4'(i / j);
          er = 4'(i % j);
        end
        issue(ea, eb, eq, er, (j == 0));
        wait_done();
      end
    end

`ifdef SEQ_DIVIDER_SIGNED_EN
    signed_op = 1'b1;
    issue(4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0);
    wait_done();
    issue(4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0);
    wait_done();
    issue(4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0);
    wait_done();
    issue(4'b1101, 4'b0000, 4'b1111, 4'b1101, 1'b1);
    wait_done();
    signed_op = 1'b0;
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
